seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Time-multiplexes NUM_DIGITS active-low seven-segment patterns onto one shared segment bus with active-low digit enables. It sits directly downstream of the per-digit hex decoders (sum and carry-out digits) and drives the board pins. Each digit slot starts with a blanking window to suppress ghosting. New patterns are double-buffered so that a frame never mixes old and new data.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (≥1)
REFRESH_DIV, 50000, clock cycles per digit slot (≥2)
BLANK_CYCLES, 1000, leading blank cycles per slot (0 ≤ BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scanning enable; low holds display dark
load  in  1  single-cycle strobe: capture seg_in
seg_in  in  7*NUM_DIGITS  active-low patterns; digit k at bits [7k+6:7k], bit 0 = segment a … bit 6 = segment g
seg_out  out  7  shared active-low segment bus; bit 0 = a … bit 6 = g
an_n  out  NUM_DIGITS  active-low digit enables; at most one bit low
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - seg_out = 7'h7F; an_n = all ones; frame_done = 0.
  - State IDLE; digit index 0; slot counter 0.
  - Shadow and active buffers all ones (blank); pending = 0.
- All outputs are registered.
- States: IDLE, BLANK, SHOW.
  - IDLE: outputs dark. If enable = 1, go to BLANK with digit 0 and counter 0.
  - BLANK: an_n = all ones, seg_out = 7'h7F, for exactly BLANK_CYCLES cycles, then go to SHOW. If BLANK_CYCLES = 0, skip BLANK and enter SHOW directly.
  - SHOW: an_n[idx] = 0 and seg_out = active[idx], for exactly REFRESH_DIV − BLANK_CYCLES cycles. Then increment idx and go to BLANK (or SHOW when BLANK_CYCLES = 0).
- Frame wrap and frame_done:
  - When idx = NUM_DIGITS−1 finishes SHOW, idx wraps to 0. This is the frame boundary.
  - frame_done is high for exactly one cycle: the first cycle of digit 0's new slot.
- Frame timing: frame length = NUM_DIGITS × REFRESH_DIV cycles exactly.
- Load handling:
  - load = 1 copies seg_in into shadow and sets pending.
  - At a frame boundary with pending = 1: active ← shadow, pending ← 0.
  - In IDLE, load writes active directly; pending stays 0.
  - load in the same cycle as a frame boundary: seg_in goes straight to active and pending is cleared.
  - A later load before the boundary overwrites shadow (last write wins).
- Latency: a load while scanning becomes visible at the first slot of the next frame.
- enable deasserted in any state: on the next edge go to IDLE, drive outputs dark, clear idx and counter, suppress frame_done. Buffers and pending are retained.
- Re-enable always restarts at BLANK (or SHOW when BLANK_CYCLES = 0), digit 0.
- Reset mid-scan: outputs dark immediately (asynchronous). Buffers return to blank.
- Slot counter width = $clog2(REFRESH_DIV). Digit index width = max(1, $clog2(NUM_DIGITS)).

Decomposition:
- Shared package seg_pkg holds:
  - SEG_BLANK = 7'h7F
  - scan_state_t enum {IDLE, BLANK, SHOW}
  - SEG_W = 7
- Natural sub-module: scan_slot_timer. It is a counter with parameter REFRESH_DIV, a clear input, and outputs blank_end and slot_end pulses.

Test Plan:
Use NUM_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2 unless stated otherwise.
1. Reset, enable=1, load once with digit0=7'h40 ("0") and digit1=7'h79 ("1") while IDLE → BLANK 2 cycles, an_n=2'b10 seg_out=7'h40 for 6 cycles, BLANK 2 cycles, an_n=2'b01 seg_out=7'h79 for 6 cycles, then frame_done=1 for 1 cycle.
2. Mid-frame load (digit0=7'h24) → current frame unchanged; digit0 shows 7'h24 starting at the next frame.
3. load coinciding with the frame boundary cycle → new data shown in that same frame. Two loads within one frame → only the second appears.
4. enable dropped during SHOW of digit 1 → next cycle an_n=2'b11, seg_out=7'h7F, no frame_done. Re-enable → BLANK on digit 0.
5. rst_n asserted mid-SHOW → same cycle an_n=2'b11 and seg_out=7'h7F, without waiting for a clock edge. After release, the display stays blank until a load.
6. BLANK_CYCLES=0, NUM_DIGITS=1 → an_n=1'b0 continuously, frame_done every 8 cycles. Assertion throughout all runs: at most one an_n bit is low.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and scan-state type for the seven-segment scan driver.
package seg_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: free-running per-slot counter with end-of-blank and end-of-slot pulses.
module scan_slot_timer #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic blank_end,
  output logic slot_end
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BE = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    slot_end  = cnt_q == CW'(REFRESH_DIV - 1);
    blank_end = (BLANK_CYCLES != 0) && (cnt_q == CW'(BE));
    cnt_d     = (clear || slot_end) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexes NUM_DIGITS active-low seven-segment patterns onto one bus,
// with a leading blank window per slot and frame-aligned double-buffered pattern updates.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        load,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic                        frame_done
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam scan_state_t FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_arr_t;

  scan_state_t             state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  seg_arr_t                shadow_q, shadow_d, active_q, active_d;
  logic                    pending_q, pending_d;
  logic [SEG_W-1:0]        seg_out_d;
  logic [NUM_DIGITS-1:0]   an_n_d, sel;
  logic                    frame_done_d, clear, blank_end, slot_end, idle, boundary;

  scan_slot_timer #(.REFRESH_DIV(REFRESH_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  always_comb begin
    idle     = state_q == IDLE;
    boundary = enable && state_q == SHOW && slot_end && idx_q == LAST;
    clear    = !enable || idle;
    state_d  = state_q;
    idx_d    = idx_q;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if (idle) begin
      state_d = FIRST;
      idx_d   = '0;
    end else if (state_q == BLANK && blank_end) begin
      state_d = SHOW;
    end else if (state_q == SHOW && slot_end) begin
      state_d = FIRST;
      idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
    end
    // While idle or exactly at the frame edge, a load bypasses the shadow so it shows at once.
    shadow_d     = load ? seg_arr_t'(seg_in) : shadow_q;
    active_d     = (load && (idle || boundary)) ? seg_arr_t'(seg_in) :
                   (boundary && pending_q) ? shadow_q : active_q;
    pending_d    = (boundary || (idle && load)) ? 1'b0 : (load || pending_q);
    sel          = '0;
    sel[idx_d]   = 1'b1;
    seg_out_d    = (state_d == SHOW) ? active_d[idx_d] : SEG_BLANK;
    an_n_d       = (state_d == SHOW) ? ~sel : '1;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shadow_q   <= '1;
      active_q   <= '1;
      pending_q  <= 1'b0;
      seg_out    <= SEG_BLANK;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      seg_out    <= seg_out_d;
      an_n       <= an_n_d;
      frame_done <= frame_done_d;
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench; a position-based frame model predicts every output cycle
// for a 2-digit blanked instance and a 1-digit unblanked instance driven by the same stimulus.
module tb_seg_scan_driver;
  localparam int R = 8;
  logic clk = 1'b0, rst_n = 1'b1, enable = 1'b0, load = 1'b0;
  logic [13:0] seg_in = '0;
  logic [6:0] seg_out, seg_out2;
  logic [1:0] an_n;
  logic [0:0] an_n2;
  logic frame_done, frame_done2;

  seg_scan_driver #(.NUM_DIGITS(2), .REFRESH_DIV(R), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .seg_in(seg_in),
    .seg_out(seg_out), .an_n(an_n), .frame_done(frame_done));
  seg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(R), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .seg_in(seg_in[6:0]),
    .seg_out(seg_out2), .an_n(an_n2), .frame_done(frame_done2));

  always #5 clk = ~clk;

  typedef struct {logic [6:0] seg; logic [1:0] an; logic fd;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0;
  int nn[2] = '{2, 1};
  int bb[2] = '{2, 0};
  int pos[2] = '{-1, -1};
  logic [6:0] act[2][2], shad[2][2];
  bit pend[2] = '{0, 0};

  task automatic model(input int k, input bit rst, input bit en, input bit ld, input logic [13:0] d);
    int fl = nn[k] * R;
    bit idle = pos[k] < 0;
    bit bnd = en && pos[k] == fl - 1;
    exp_t e;
    if (rst) begin
      pos[k] = -1;
      pend[k] = 0;
      for (int j = 0; j < 2; j++) begin act[k][j] = 7'h7F; shad[k][j] = 7'h7F; end
    end else begin
      for (int j = 0; j < nn[k]; j++) begin
        if (ld && (idle || bnd)) act[k][j] = d[7*j +: 7];
        else if (bnd && pend[k]) act[k][j] = shad[k][j];
        if (ld) shad[k][j] = d[7*j +: 7];
      end
      if (bnd || (idle && ld)) pend[k] = 0;
      else if (ld) pend[k] = 1;
      pos[k] = !en ? -1 : idle ? 0 : (pos[k] + 1) % fl;
    end
    e.fd = !rst && bnd;
    if (pos[k] >= 0 && pos[k] % R >= bb[k]) begin
      e.seg = act[k][pos[k] / R];
      e.an = ~(2'b01 << (pos[k] / R));
    end else begin
      e.seg = 7'h7F;
      e.an = 2'b11;
    end
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(input bit en, input bit ld, input logic [13:0] d);
    enable = en;
    load = ld;
    seg_in = d;
    @(posedge clk);
    model(0, !rst_n, en, ld, d);
    model(1, !rst_n, en, ld, d);
    #1;
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < 40 && pos[0] != p; i++) step(1, 0, 14'($urandom));
    if (pos[0] != p) begin
      checks++; errors++;
      $display("FAIL sync: model position %0d, wanted %0d", pos[0], p);
    end
  endtask

  task automatic check_dark(input string name);
    checks++;
    if ({seg_out, an_n, frame_done, seg_out2, an_n2, frame_done2} !== {7'h7F, 2'b11, 1'b0, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: seg=%h an=%b fd=%b seg2=%h an2=%b fd2=%b, want dark", name,
               seg_out, an_n, frame_done, seg_out2, an_n2, frame_done2);
    end
  endtask

  task automatic async_reset(input int hold);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_dark("async_reset");
    repeat (hold) step(1, 0, 14'($urandom));
    #2 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      checks++;
      if ({seg_out, an_n, frame_done} !== {e0.seg, e0.an, e0.fd}) begin
        errors++;
        $display("FAIL scan2d t=%0t: seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b", $time,
                 seg_out, an_n, frame_done, e0.seg, e0.an, e0.fd);
      end
    end
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      checks++;
      if ({seg_out2, 1'b1, an_n2, frame_done2} !== {e1.seg, e1.an, e1.fd}) begin
        errors++;
        $display("FAIL scan1d t=%0t: seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b", $time,
                 seg_out2, an_n2, frame_done2, e1.seg, e1.an[0], e1.fd);
      end
    end
    if (rst_n) assert ($countones(~an_n) <= 1)
      else begin errors++; $display("FAIL onehot: an_n=%b", an_n); end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 check_dark("reset");
    repeat (2) step(0, 0, '0);
    #2 rst_n = 1'b1;
    step(1, 1, {7'h79, 7'h40});
    repeat (34) step(1, 0, 14'($urandom));
    run_until(3);
    step(1, 1, {7'h79, 7'h24});
    repeat (30) step(1, 0, 14'($urandom));
    run_until(15);
    step(1, 1, {7'h06, 7'h5B});
    run_until(2);
    step(1, 1, {7'h4F, 7'h66});
    run_until(9);
    step(1, 1, {7'h6D, 7'h7D});
    repeat (34) step(1, 0, 14'($urandom));
    run_until(12);
    step(0, 0, '0);
    repeat (3) step(0, 0, '0);
    repeat (20) step(1, 0, 14'($urandom));
    run_until(4);
    async_reset(2);
    repeat (20) step(1, 0, 14'($urandom));
    step(1, 1, {7'h12, 7'h03});
    repeat (40) step(1, 0, 14'($urandom));
    repeat (1500) step($urandom_range(0, 99) < 97, $urandom_range(0, 9) == 0, 14'($urandom));
    async_reset(1);
    repeat (20) step(1, 0, 14'($urandom));
    @(negedge clk);
    #1 $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
